// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_engine: 8-bit UART transmitter, LSB first, 1 start, STOP_BITS stop.
// Define UART_TX_PARITY_EN to insert an even parity bit.        Rev 1.0
// ============================================================================
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_tx,
  input  logic [7:0] uart_data_in,
  input  logic       stop,
  output logic       uart_tx,
  output logic       uart_tx_busy,
  output logic       done
);

  localparam int                BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        C_STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [BAUD_W-1:0] r_baud, w_baud;
  logic [2:0]        r_bit, w_bit;
  logic [7:0]        r_shreg, w_shreg;
  logic              r_tx, w_tx;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              w_baud_end;
  logic              w_frame_end;
  logic              w_accept;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_baud_end = (r_baud == C_BAUD_LAST);

  always_comb begin
    w_state     = r_state;
    w_baud      = r_baud;
    w_bit       = r_bit;
    w_shreg     = r_shreg;
    w_tx        = r_tx;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_frame_end = 1'b0;

    if (r_state != ST_IDLE) begin
      w_baud = w_baud_end ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      ST_START: begin
        if (w_baud_end) begin
          w_tx    = r_shreg[0];
          w_shreg = {1'b0, r_shreg[7:1]};
          w_bit   = '0;
          w_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx    = r_parity;
            w_state = ST_PARITY;
`else
            w_tx    = 1'b1;
            w_bit   = '0;
            w_state = ST_STOP;
`endif
          end else begin
            w_tx    = r_shreg[0];
            w_shreg = {1'b0, r_shreg[7:1]};
            w_bit   = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_end) begin
          w_tx    = 1'b1;
          w_bit   = '0;
          w_state = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_baud_end) begin
          if (r_bit == C_STOP_LAST) begin
            w_frame_end = 1'b1;
            w_busy      = 1'b0;
            w_done      = 1'b1;
            w_state     = ST_IDLE;
          end else begin
            w_bit = r_bit + 3'd1;
          end
        end
      end
      default: ;
    endcase

    // A request present on the last stop-bit edge chains straight into the next frame.
    w_accept = ((r_state == ST_IDLE) || w_frame_end) && init_tx && !stop;
    if (w_accept) begin
      w_shreg = uart_data_in;
      w_tx    = 1'b0;
      w_busy  = 1'b1;
      w_baud  = '0;
      w_bit   = '0;
      w_state = ST_START;
    end

    if (stop && (r_state != ST_IDLE)) begin
      w_state = ST_IDLE;
      w_tx    = 1'b1;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_baud  = '0;
      w_bit   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shreg <= w_shreg;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^uart_data_in;
    end
  end
`endif

  assign uart_tx      = r_tx;
  assign uart_tx_busy = r_busy;
  assign done         = r_done;

endmodule
`default_nettype wire
